// File: rtl/dma_copy_master.sv
// dma_copy_master: word-by-word block copy engine driving a single-cycle data memory port.
// Optional DMA_FILL_EN adds a fill mode that writes a constant word without reading.
module dma_copy_master #(
    parameter int LEN_BITS  = 9,
    parameter int ADDR_STEP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [LEN_BITS-1:0] len_words,
`ifdef DMA_FILL_EN
    input  logic                fill_mode,
    input  logic [31:0]         fill_data,
`endif
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [LEN_BITS-1:0] words_done,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_next;
    logic [31:0] src, dst, data, fill_word;
    logic [LEN_BITS-1:0] remaining, count;
    logic err_q, fill_q, fill_in, load, fail, capture, step, src_ok, dst_ok;
`ifdef DMA_FILL_EN
    assign fill_in   = fill_mode;
    assign fill_word = fill_data;
`else
    assign fill_in   = 1'b0;
    assign fill_word = 32'h0;
`endif
    // The 0x4xxxxxxx region is off limits, checked on the live (possibly wrapped) pointer.
    assign src_ok = src[31:28] != 4'h4;
    assign dst_ok = dst[31:28] != 4'h4;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        load = 1'b0;
        fail = 1'b0;
        capture = 1'b0;
        step = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        mem_addr = 32'h0;
        mem_wdata = 32'h0;
        case (state)
            IDLE: if (start) begin
                load = 1'b1;
                if (len_words == '0) state_next = DONE;
                else if (dst_addr[1:0] != 2'b0 || (!fill_in && src_addr[1:0] != 2'b0)) fail = 1'b1;
                else state_next = fill_in ? WRITE : READ;
            end
            READ: begin
                mem_rd = src_ok;
                mem_addr = src_ok ? src : 32'h0;
                if (abort) state_next = IDLE;
                else if (!src_ok) begin
                    fail = 1'b1;
                    state_next = IDLE;
                end else begin
                    capture = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_wr = dst_ok;
                mem_addr = dst_ok ? dst : 32'h0;
                mem_wdata = dst_ok ? data : 32'h0;
                if (abort) state_next = IDLE;
                else if (!dst_ok) begin
                    fail = 1'b1;
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    state_next = remaining == LEN_BITS'(1) ? DONE : (fill_q ? WRITE : READ);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            src <= 32'h0;
            dst <= 32'h0;
            data <= 32'h0;
            remaining <= '0;
            count <= '0;
            err_q <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            if (load) begin
                src <= src_addr;
                dst <= dst_addr;
                remaining <= len_words;
                count <= '0;
                err_q <= fail;
                fill_q <= fill_in;
                data <= fill_word;
            end else if (fail) err_q <= 1'b1;
            if (capture) begin
                data <= mem_rdata;
                src <= src + 32'(ADDR_STEP);
            end
            if (step) begin
                dst <= dst + 32'(ADDR_STEP);
                count <= count + LEN_BITS'(1);
                remaining <= remaining - LEN_BITS'(1);
            end
        end
    assign busy = state == READ || state == WRITE;
    assign done = state == DONE;
    assign err = err_q;
    assign words_done = count;
endmodule

// File: tb/tb_dma_copy_master.sv
// tb_dma_copy_master: directed copy/abort/reset/error scenarios with a write scoreboard.
module tb_dma_copy_master;
    logic clk = 0, reset = 1, start = 0, abort = 0;
    logic [31:0] src_addr = 0, dst_addr = 0, mem_rdata, mem_addr, mem_wdata;
    logic [8:0] len_words = 0, words_done;
    logic busy, done, err, mem_rd, mem_wr;
`ifdef DMA_FILL_EN
    logic fill_mode = 0;
    logic [31:0] fill_data = 0;
`endif
    logic [31:0] mem [0:255];
    logic [63:0] exp_q [$];
    logic no_access = 0, no_rd = 0;
    int pass = 0, total = 0, done_seen = 0;
    dma_copy_master dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
`ifdef DMA_FILL_EN
        .fill_mode(fill_mode), .fill_data(fill_data),
`endif
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else pass++;
    endtask
    // Monitor: every write is popped against the scoreboard; illegal accesses are flagged.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (mem_wr) begin
            if (exp_q.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
            else check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
        if (mem_rd || mem_wr) begin
            check("region", {63'h0, mem_addr[31:28] == 4'h4}, 64'h0);
            check("rd_wr_excl", {63'h0, mem_rd && mem_wr}, 64'h0);
        end
        if (no_access && (mem_rd || mem_wr || busy)) check("no_access", {mem_rd, mem_wr, busy}, 0);
        if (no_rd && mem_rd) check("no_rd", {63'h0, mem_rd}, 64'h0);
    end
    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [8:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len_words = n;
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
    endtask
    task automatic wait_done(input string name, input int exp_cycle);
        int c = 1;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        check(name, done ? c : 999, exp_cycle);
    endtask
    task automatic push(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 0;
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        mem[254] = 32'hA5; mem[255] = 32'hA6;
        #12;
        check("reset_outputs", {busy, done, err, words_done, mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        reset = 0;
        // Basic 4-word copy
        for (int i = 0; i < 4; i++) push(32'h40 + 4 * i, i + 1);
        go(32'h0, 32'h40, 4);
        check("busy_c1", {63'h0, busy}, 1);
        wait_done("copy_done_cycle", 9);
        check("copy_words_done", {55'h0, words_done}, 4);
        check("copy_err", {63'h0, err}, 0);
        @(negedge clk);
        check("copy_queue_empty", exp_q.size(), 0);
        check("mem_0x4c", mem[19], 4);
        // Misaligned source
        no_access = 1;
        go(32'h2, 32'h40, 1);
        check("misaligned_err", {62'h0, err, busy}, 2);
        repeat (3) @(negedge clk);
        check("misaligned_err_sticky", {63'h0, err}, 1);
        // len=0 after error: err cleared, done in cycle 1
        go(32'h0, 32'h40, 0);
        check("len0_err_clear", {63'h0, err}, 0);
        wait_done("len0_done_cycle", 1);
        @(negedge clk);
        no_access = 0;
        check("len0_done_pulse", {63'h0, done}, 0);
        // Source walks into the forbidden region
        push(32'h100, 32'hA5);
        push(32'h104, 32'hA6);
        go(32'h3FFFFFF8, 32'h100, 4);
        repeat (5) @(negedge clk);
        check("region_err", {62'h0, err, busy}, 2);
        check("region_words_done", {55'h0, words_done}, 2);
        check("region_queue_empty", exp_q.size(), 0);
        // Abort during READ of word 2 (cycle 5)
        done_seen = 0;
        push(32'h200, 1);
        push(32'h204, 2);
        go(32'h0, 32'h200, 8);
        repeat (4) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        no_access = 1;
        check("abort_idle", {62'h0, busy, err}, 0);
        repeat (6) @(negedge clk);
        no_access = 0;
        check("abort_words_done", {55'h0, words_done}, 2);
        check("abort_no_done", done_seen, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        // Asynchronous reset during WRITE of word 1 (cycle 4)
        push(32'h300, 1);
        go(32'h0, 32'h300, 8);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_write", {mem_wr, mem_addr}, {1'b1, 32'h304});
        #1 reset = 1;
        #1;
        check("async_reset_outputs", {busy, done, err, words_done, mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        check("reset_queue_empty", exp_q.size(), 0);
`ifdef DMA_FILL_EN
        // Fill mode: one WRITE per word, no reads
        for (int i = 0; i < 3; i++) push(32'h80 + 4 * i, 32'hDEADBEEF);
        no_rd = 1;
        fill_mode = 1;
        fill_data = 32'hDEADBEEF;
        go(32'h2, 32'h80, 3);
        fill_mode = 0;
        wait_done("fill_done_cycle", 4);
        check("fill_words_done", {55'h0, words_done}, 3);
        @(negedge clk);
        no_rd = 0;
        check("fill_queue_empty", exp_q.size(), 0);
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
